// File: rtl/serpent_pkg.sv
// Shared constants and bit-index helpers for the Serpent FP/IP permutation.
package serpent_pkg;

  localparam int   BLOCK_W = 128;
  localparam logic MODE_FP = 1'b0;
  localparam logic MODE_IP = 1'b1;

  // FP: out[127-(32j+k)] = in[4k+j]; returns the source bit for output bit i.
  function automatic logic [6:0] fp_src(input logic [6:0] i);
    logic [6:0] m;
    m = 7'd127 - i;
    return {m[4:0], m[6:5]};
  endfunction

  // IP: out[4k+j] = in[127-(32j+k)]; returns the source bit for output bit i.
  function automatic logic [6:0] ip_src(input logic [6:0] i);
    return 7'd127 - {i[1:0], i[6:2]};
  endfunction

endpackage

// File: rtl/serpent_perm_pipe_if.sv
// Stream bundle for serpent_perm_pipe; i_/o_ names are from the unit's point of view.
interface serpent_perm_pipe_if #(
  parameter int LANES = 1,
  parameter int TAGW  = 8
);
  import serpent_pkg::*;

  // A beat transfers on a rising edge where valid && ready; the producer holds
  // valid and payload stable until that edge, and ready may depend on valid.
  logic                       i_valid;
  logic                       o_ready;
  logic                       i_mode;
  logic [TAGW-1:0]            i_tag;
  logic [BLOCK_W*LANES-1:0]   i_data;

  logic                       o_valid;
  logic                       i_ready;
  logic                       o_mode;
  logic [TAGW-1:0]            o_tag;
  logic [BLOCK_W*LANES-1:0]   o_data;

  modport slave (
    input  i_valid, i_mode, i_tag, i_data, i_ready,
    output o_ready, o_valid, o_mode, o_tag, o_data
  );

  modport master (
    output i_valid, i_mode, i_tag, i_data, i_ready,
    input  o_ready, o_valid, o_mode, o_tag, o_data
  );

endinterface

// File: rtl/serpent_bit_perm.sv
// Combinational Serpent FP / IP bit permutation of one 128-bit block.
module serpent_bit_perm
  import serpent_pkg::*;
(
  input  logic               i_mode,
  input  logic [BLOCK_W-1:0] i_data,
  output logic [BLOCK_W-1:0] o_data
);

  logic [BLOCK_W-1:0] w_fp;
  logic [BLOCK_W-1:0] w_ip;

  for (genvar g = 0; g < BLOCK_W; g++) begin : g_bit
    assign w_fp[g] = i_data[fp_src(7'(g))];
    assign w_ip[g] = i_data[ip_src(7'(g))];
  end

  assign o_data = (i_mode == MODE_IP) ? w_ip : w_fp;

endmodule

// File: rtl/serpent_perm_pipe.sv
// Two-stage multi-lane Serpent FP/IP permutation pipe with valid/ready flow control.
module serpent_perm_pipe
  import serpent_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAGW  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  serpent_perm_pipe_if.slave   bus,
  output logic [31:0]          o_count
);

  localparam int DW = BLOCK_W * LANES;

  logic            r_s1_valid;
  logic            r_s1_mode;
  logic [TAGW-1:0] r_s1_tag;
  logic [DW-1:0]   r_s1_data;
  logic            r_s2_valid;
  logic            r_s2_mode;
  logic [TAGW-1:0] r_s2_tag;
  logic [DW-1:0]   r_s2_data;
  logic [31:0]     r_count;

  logic            w_out_fire;
  logic            w_s2_load;
  logic            w_s1_adv;
  logic            w_s1_load;
  logic            w_in_fire;
  logic            w_ready;
  logic [DW-1:0]   w_perm;

  assign w_out_fire = r_s2_valid && bus.i_ready;
  assign w_s2_load  = !r_s2_valid || w_out_fire;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign w_s1_load  = !r_s1_valid || w_s1_adv;
  // Held low during reset so nothing is taken while the pipe is being flushed.
  assign w_ready    = i_rst_n && w_s1_load;
  assign w_in_fire  = bus.i_valid && w_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    serpent_bit_perm u_perm (
      .i_mode (r_s1_mode),
      .i_data (r_s1_data[g*BLOCK_W +: BLOCK_W]),
      .o_data (w_perm[g*BLOCK_W +: BLOCK_W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_FP;
      r_s1_tag   <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mode  <= MODE_FP;
      r_s2_tag   <= '0;
      r_s2_data  <= '0;
      r_count    <= '0;
    end else begin
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      // Payloads only move with a real beat, so empty stages keep old contents.
      if (w_s1_adv) begin
        r_s2_mode <= r_s1_mode;
        r_s2_tag  <= r_s1_tag;
        r_s2_data <= w_perm;
      end
      if (w_s1_load) r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_mode <= bus.i_mode;
        r_s1_tag  <= bus.i_tag;
        r_s1_data <= bus.i_data;
      end
      if (w_out_fire) r_count <= r_count + 32'd1;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_s2_valid;
  assign bus.o_mode  = r_s2_mode;
  assign bus.o_tag   = r_s2_tag;
  assign bus.o_data  = r_s2_data;
  assign o_count     = r_count;

endmodule

// File: doc/serpent_perm_pipe.md
# serpent_perm_pipe

Pipelined, multi-lane Serpent bit-permutation unit with a valid/ready stream interface. Each beat carries LANES independent 128-bit blocks and a per-beat mode bit that selects either the final permutation (FP) or its inverse, the initial permutation (IP). The unit sits between the bitslice round core and the XTS tweak/IO datapath, so one instance serves both encrypt-side and decrypt-side conversions.

## Interface
- LANES, 1, number of 128-bit blocks per beat (1..4)
- TAGW, 8, width of opaque sideband tag carried alongside each beat (1..32)
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  reset; synchronous and active-low, one clock
- i_valid  input  1  input beat valid
- o_ready  output  1  unit can accept an input beat this cycle
- i_mode  input  1  0 = FP, 1 = IP; sampled with the beat
- i_tag  input  TAGW  sideband tag, passed through unchanged
- i_data  input  128*LANES  lane n occupies bits [128n+127:128n]
- o_valid  output  1  output beat valid
- i_ready  input  1  downstream accepts the output beat
- o_mode  output  1  mode of the output beat
- o_tag  output  TAGW  tag of the output beat
- o_data  output  128*LANES  permuted blocks, same lane mapping
- o_count  output  32  number of output beats delivered since reset

## Operation
- Bit mapping per lane, for j in 0..3 and k in 0..31:
  - FP: out[127-(32j+k)] = in[4k+j].
  - IP: out[4k+j] = in[127-(32j+k)].
- IP(FP(x)) = x and FP(IP(x)) = x for every lane.
- Two pipeline stages:
  - S1 registers {mode, tag, raw data}.
  - S2 registers {mode, tag, permuted data}. The permutation is combinational between S1 and S2.
- Each stage holds a valid flag, so the unit buffers two beats.
- Stage S2 loads when S2 is empty or the output handshake (o_valid && i_ready) fires.
- Stage S1 loads when S1 is empty or S1 advances into S2.
- o_ready = !s1_valid || s1_advance. This is a combinational path from i_ready and is allowed.
- Input handshake: i_valid && o_ready. The beat is captured at that edge.
- Payload rules:
  - o_data, o_tag and o_mode stay stable while o_valid && !i_ready.
  - Payload registers hold their value when their stage is empty; they are not cleared.
- o_count increments by 1 on each output handshake and wraps from 2^32-1 to 0.
- Reset mid-stream drops both buffered beats. No beat is output after reset until a new input is accepted.
- Simultaneous input handshake, S1->S2 move and output handshake in the same cycle: all three occur. Throughput stays 1 beat/cycle.

## Timing
- Latency: input accepted at edge N gives o_valid at edge N+2 when there is no backpressure.
- Throughput: 1 beat per cycle with i_ready held high.
- Backpressure:
  - With i_ready low, the unit accepts exactly 2 beats, then o_ready drops.
  - o_ready rises in the same cycle that i_ready rises.
- Reset values: o_valid 0, o_mode 0, o_tag 0, o_data 0, o_count 0, internal valids 0.
- o_ready reads 0 while i_rst_n is low and 1 in the first cycle after release.
- i_mode, i_tag and i_data are ignored when i_valid is low.

## Structure
- Package serpent_pkg holds:
  - BLOCK_W = 128.
  - Mode encodings MODE_FP = 1'b0 and MODE_IP = 1'b1.
  - Index functions fp_src(i) and ip_src(i) implementing the mapping above.
- Sub-module serpent_bit_perm (combinational, one 128-bit block, mode input). Instantiate it LANES times with a generate loop between S1 and S2.
- The top level contains only the two stage registers, the valid/ready control and the counter.

## Test plan
- Single-bit FP, LANES=1:
  - in 128'h1 -> out 128'h8000...0.
  - in bit 1 -> out bit 95, i.e. 128'h00000000_80000000_00000000_00000000.
  - o_valid arrives exactly 2 cycles after acceptance.
- Round trip:
  - 1000 random blocks in FP, then each output fed back in IP, must return the original value.
  - The same check with IP first, then FP.
- LANES=4, mixed modes:
  - Lanes carry 128'h0, all-ones, 128'h1 and 128'h0123456789ABCDEF_FEDCBA9876543210.
  - Modes alternate per beat, i_ready held high.
  - Each lane must match the reference model independently.
  - Tags 0..255 must emerge in order.
- Backpressure:
  - Hold i_ready low with i_valid high: exactly 2 beats accepted, o_ready low from the third cycle, o_data stable throughout.
  - Then release i_ready: beats drain in order with no loss or duplication.
- Reset mid-stream:
  - Assert i_rst_n=0 for one cycle with both stages full: next cycle o_valid=0, o_count=0, o_data=0.
  - Beats accepted before the reset never appear.
- Counter wrap: force o_count to 32'hFFFF_FFFF, then complete one output handshake -> o_count=0.
